// File: rtl/exwb_stage_skid.sv
// EX->WB pipeline stage with valid/ready handshake, 2-entry skid buffer,
// synchronous flush, bubble gating of control bits and a saturating stall counter.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             drop held entries and the same-cycle input
//   in_valid/in_ready upstream handshake (in_ready depends only on state)
//   in_alu/in_datamem/in_addr/in_rd/in_ctrl   incoming payload
//   out_valid/out_ready  downstream handshake
//   out_alu/out_datamem/out_addr/out_rd/out_ctrl  head-entry payload
//   stall_cnt         cycles with out_valid & !out_ready, saturating
module exwb_stage_skid #(
    parameter int DATA_W      = 32,
    parameter int RD_W        = 6,
    parameter int CTRL_W      = 9,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_alu,
    input  logic [DATA_W-1:0]      in_datamem,
    input  logic [DATA_W-1:0]      in_addr,
    input  logic [RD_W-1:0]        in_rd,
    input  logic [CTRL_W-1:0]      in_ctrl,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_alu,
    output logic [DATA_W-1:0]      out_datamem,
    output logic [DATA_W-1:0]      out_addr,
    output logic [RD_W-1:0]        out_rd,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int PW = 3 * DATA_W + RD_W + CTRL_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [PW-1:0]          head_q;
    logic [PW-1:0]          skid_q;
    logic [STALL_CNT_W-1:0] stall_q;

    logic [PW-1:0] in_pl;
    logic          accept;
    logic          drain;

    assign in_pl = {in_alu, in_datamem, in_addr, in_rd, in_ctrl};

    // Both handshake outputs come straight from the state register, so
    // there is no combinational path from out_ready to in_ready.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);

    assign accept = in_valid & in_ready & ~flush;
    assign drain  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            if (out_valid && !out_ready && !(&stall_q)) begin
                stall_q <= stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
            end
            if (flush) begin
                state_q <= EMPTY;
            end else begin
                unique case (state_q)
                    EMPTY: begin
                        if (accept) begin
                            head_q  <= in_pl;
                            state_q <= HALF;
                        end
                    end
                    HALF: begin
                        if (accept && drain) begin
                            head_q <= in_pl;
                        end else if (accept) begin
                            skid_q  <= in_pl;
                            state_q <= FULL;
                        end else if (drain) begin
                            state_q <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (drain) begin
                            head_q  <= skid_q;
                            state_q <= HALF;
                        end
                    end
                    default: state_q <= EMPTY;
                endcase
            end
        end
    end

    assign out_alu     = head_q[PW-1 -: DATA_W];
    assign out_datamem = head_q[PW-DATA_W-1 -: DATA_W];
    assign out_addr    = head_q[PW-2*DATA_W-1 -: DATA_W];
    assign out_rd      = head_q[CTRL_W +: RD_W];
    // Bubbles must never write registers or take a branch.
    assign out_ctrl    = out_valid ? head_q[CTRL_W-1:0] : '0;
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_exwb_stage_skid.sv
// Bench for exwb_stage_skid: depth-2 FIFO reference model plus
// a table of hand-computed vectors and a few directed sequences.
module tb_exwb_stage_skid;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_alu;
    logic [31:0] in_datamem;
    logic [31:0] in_addr;
    logic [5:0]  in_rd;
    logic [8:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_alu;
    logic [31:0] out_datamem;
    logic [31:0] out_addr;
    logic [5:0]  out_rd;
    logic [8:0]  out_ctrl;
    logic [3:0]  stall_cnt;

    always #5 clk = ~clk;

    exwb_stage_skid #(
        .DATA_W(32), .RD_W(6), .CTRL_W(9), .STALL_CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu(in_alu), .in_datamem(in_datamem), .in_addr(in_addr),
        .in_rd(in_rd), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu(out_alu), .out_datamem(out_datamem), .out_addr(out_addr),
        .out_rd(out_rd), .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] dm;
        logic [31:0] ad;
        logic [5:0]  rd;
        logic [8:0]  ctrl;
    } ent_t;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [31:0] alu;
        logic [8:0]  ctrl;
        logic        ev;
        logic        er;
        logic [31:0] ealu;
        logic [3:0]  est;
    } vec_t;

    ent_t       sb[$];
    logic [3:0] m_stall;
    int         total = 0;
    int         bad   = 0;
    vec_t       vt[14];
    bit         seen_c;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_model();
        chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, sb.size() != 2});
        chk("stall_cnt", {28'd0, stall_cnt}, {28'd0, m_stall});
        if (sb.size() != 0) begin
            chk("out_alu", out_alu, sb[0].alu);
            chk("out_datamem", out_datamem, sb[0].dm);
            chk("out_addr", out_addr, sb[0].ad);
            chk("out_rd", {26'd0, out_rd}, {26'd0, sb[0].rd});
            chk("out_ctrl", {23'd0, out_ctrl}, {23'd0, sb[0].ctrl});
        end else begin
            chk("bubble_ctrl", {23'd0, out_ctrl}, 32'd0);
        end
    endtask

    // Called just after a falling edge; applies one cycle of stimulus.
    task automatic tick(input logic iv, input logic ordy, input logic fl,
                        input logic [31:0] alu, input logic [8:0] ctrl);
        ent_t e;
        int   n;
        e.alu  = alu;
        e.dm   = alu ^ 32'h5A5A_0000;
        e.ad   = alu + 32'h100;
        e.rd   = alu[5:0];
        e.ctrl = ctrl;
        in_valid   = iv;
        out_ready  = ordy;
        flush      = fl;
        in_alu     = e.alu;
        in_datamem = e.dm;
        in_addr    = e.ad;
        in_rd      = e.rd;
        in_ctrl    = e.ctrl;
        @(posedge clk);
        n = sb.size();
        if (n != 0 && !ordy && m_stall != 4'hF) m_stall = m_stall + 4'd1;
        if (fl) begin
            sb.delete();
        end else begin
            if (n != 0 && ordy) void'(sb.pop_front());
            if (iv && n < 2) sb.push_back(e);
        end
        @(negedge clk);
        if (out_valid && out_alu == 32'hC) seen_c = 1'b1;
        check_model();
    endtask

    initial begin
        //        iv ordy fl alu      ctrl    ev er ealu     est
        vt[0]  = '{1, 0, 0, 32'hA,  9'h0A3, 1, 1, 32'hA,  4'd0};
        vt[1]  = '{1, 0, 0, 32'hB,  9'h0B1, 1, 0, 32'hA,  4'd1};
        vt[2]  = '{1, 0, 0, 32'hD,  9'h0D0, 1, 0, 32'hA,  4'd2};
        vt[3]  = '{0, 1, 0, 32'h0,  9'h000, 1, 1, 32'hB,  4'd2};
        vt[4]  = '{0, 1, 0, 32'h0,  9'h000, 0, 1, 32'h0,  4'd2};
        vt[5]  = '{1, 0, 0, 32'hE,  9'h1E0, 1, 1, 32'hE,  4'd2};
        vt[6]  = '{1, 0, 0, 32'hF,  9'h0F0, 1, 0, 32'hE,  4'd3};
        vt[7]  = '{1, 0, 1, 32'hC,  9'h1CC, 0, 1, 32'h0,  4'd4};
        vt[8]  = '{0, 1, 0, 32'h0,  9'h000, 0, 1, 32'h0,  4'd4};
        vt[9]  = '{1, 1, 0, 32'h11, 9'h011, 1, 1, 32'h11, 4'd4};
        vt[10] = '{0, 1, 0, 32'h0,  9'h000, 0, 1, 32'h0,  4'd4};
        vt[11] = '{1, 0, 0, 32'h12, 9'h012, 1, 1, 32'h12, 4'd4};
        vt[12] = '{1, 1, 1, 32'h13, 9'h013, 0, 1, 32'h0,  4'd4};
        vt[13] = '{0, 0, 0, 32'h0,  9'h1FF, 0, 1, 32'h0,  4'd4};

        seen_c     = 1'b0;
        m_stall    = 4'd0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_alu     = '0;
        in_datamem = '0;
        in_addr    = '0;
        in_rd      = '0;
        in_ctrl    = '0;
        repeat (2) @(negedge clk);
        check_model();
        rst_n = 1'b1;
        @(negedge clk);

        // Streaming at full rate
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, 1'b1, 1'b0, 32'(i), 9'(i));
            chk("stream_alu", out_alu, 32'(i));
            chk("stream_ready", {31'd0, in_ready}, 32'd1);
        end
        tick(1'b0, 1'b1, 1'b0, 32'h0, 9'h0);

        // Backpressure, flush, bubble vectors
        for (int i = 0; i < 14; i++) begin
            tick(vt[i].iv, vt[i].ordy, vt[i].fl, vt[i].alu, vt[i].ctrl);
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid},
                {31'd0, vt[i].ev});
            chk($sformatf("vec%0d_ready", i), {31'd0, in_ready},
                {31'd0, vt[i].er});
            chk($sformatf("vec%0d_stall", i), {28'd0, stall_cnt},
                {28'd0, vt[i].est});
            if (vt[i].ev) chk($sformatf("vec%0d_alu", i), out_alu, vt[i].ealu);
        end
        chk("flushed_0xC_seen", {31'd0, seen_c}, 32'd0);
        chk("bubble_out_ctrl", {23'd0, out_ctrl}, 32'd0);

        // Saturation: hold out_ready low for 20 cycles
        tick(1'b1, 1'b0, 1'b0, 32'h21, 9'h021);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b0, 32'h0, 9'h0);
        chk("stall_sat", {28'd0, stall_cnt}, 32'd15);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 9'h0);
        chk("stall_hold", {28'd0, stall_cnt}, 32'd15);

        // Reset mid-FULL, asserted between edges
        tick(1'b1, 1'b0, 1'b0, 32'h22, 9'h022);
        chk("pre_reset_full", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        m_stall = 4'd0;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ctrl", {23'd0, out_ctrl}, 32'd0);
        chk("rst_stall", {28'd0, stall_cnt}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_alu", out_alu, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1, 1'b1, 1'b0, 32'h33, 9'h133);
        tick(1'b0, 1'b1, 1'b0, 32'h0, 9'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
